// File: rtl/as_pack.sv
// Shared constants for the GPIO extension block: register byte offsets,
// identification word, register reset values and the register decoder.
package as_pack;

  // Register byte offsets; address bits [6:3] select the register.
  localparam logic [7:0] GPIO_EXT_ID_OFFS_C       = 8'h00;
  localparam logic [7:0] GPIO_EXT_DIR_OFFS_C      = 8'h08;
  localparam logic [7:0] GPIO_EXT_OUT_OFFS_C      = 8'h10;
  localparam logic [7:0] GPIO_EXT_OUT_SET_OFFS_C  = 8'h18;
  localparam logic [7:0] GPIO_EXT_OUT_CLR_OFFS_C  = 8'h20;
  localparam logic [7:0] GPIO_EXT_OUT_TGL_OFFS_C  = 8'h28;
  localparam logic [7:0] GPIO_EXT_IN_OFFS_C       = 8'h30;
  localparam logic [7:0] GPIO_EXT_RISE_EN_OFFS_C  = 8'h38;
  localparam logic [7:0] GPIO_EXT_FALL_EN_OFFS_C  = 8'h40;
  localparam logic [7:0] GPIO_EXT_IRQ_STAT_OFFS_C = 8'h48;
  localparam logic [7:0] GPIO_EXT_IRQ_MASK_OFFS_C = 8'h50;
  localparam logic [7:0] GPIO_EXT_DEB_CNT_OFFS_C  = 8'h58;

  // Identification word returned by the ID register.
  localparam logic [63:0] GPIO_EXT_ID_C = 64'h4153_4750_494F_0100;

  // Register reset values.
  localparam logic [63:0] GPIO_EXT_DIR_RST_C      = 64'h0;
  localparam logic [63:0] GPIO_EXT_OUT_RST_C      = 64'h0;
  localparam logic [63:0] GPIO_EXT_RISE_EN_RST_C  = 64'h0;
  localparam logic [63:0] GPIO_EXT_FALL_EN_RST_C  = 64'h0;
  localparam logic [63:0] GPIO_EXT_IRQ_STAT_RST_C = 64'h0;
  localparam logic [63:0] GPIO_EXT_IRQ_MASK_RST_C = 64'h0;
  localparam logic [63:0] GPIO_EXT_DEB_CNT_RST_C  = 64'h0;

  // Decoded register select.
  typedef enum logic [3:0] {
    REG_ID, REG_DIR, REG_OUT, REG_OUT_SET, REG_OUT_CLR, REG_OUT_TGL, REG_IN,
    REG_RISE_EN, REG_FALL_EN, REG_IRQ_STAT, REG_IRQ_MASK, REG_DEB_CNT,
    REG_NONE
  } reg_sel_e;

  // Map address bits [6:3] onto a register; unmapped slots give REG_NONE.
  function automatic reg_sel_e reg_decode(input logic [3:0] idx);
    reg_sel_e r;
    case (idx)
      GPIO_EXT_ID_OFFS_C[6:3]:       r = REG_ID;
      GPIO_EXT_DIR_OFFS_C[6:3]:      r = REG_DIR;
      GPIO_EXT_OUT_OFFS_C[6:3]:      r = REG_OUT;
      GPIO_EXT_OUT_SET_OFFS_C[6:3]:  r = REG_OUT_SET;
      GPIO_EXT_OUT_CLR_OFFS_C[6:3]:  r = REG_OUT_CLR;
      GPIO_EXT_OUT_TGL_OFFS_C[6:3]:  r = REG_OUT_TGL;
      GPIO_EXT_IN_OFFS_C[6:3]:       r = REG_IN;
      GPIO_EXT_RISE_EN_OFFS_C[6:3]:  r = REG_RISE_EN;
      GPIO_EXT_FALL_EN_OFFS_C[6:3]:  r = REG_FALL_EN;
      GPIO_EXT_IRQ_STAT_OFFS_C[6:3]: r = REG_IRQ_STAT;
      GPIO_EXT_IRQ_MASK_OFFS_C[6:3]: r = REG_IRQ_MASK;
      GPIO_EXT_DEB_CNT_OFFS_C[6:3]:  r = REG_DEB_CNT;
      default:                       r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/as_gpio_sync_deb.sv
// Pad input conditioning: two-flop synchroniser followed by an optional
// prescaled debouncer. With deb_cnt_i == 0 the synchronised value passes
// straight into in_o; otherwise a bit only updates when it has been seen
// at the same level on two consecutive prescaler ticks.
module as_gpio_sync_deb #(
  parameter int NR_GPIOS  = 8,
  parameter int DEB_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NR_GPIOS-1:0]  pad_i,
  input  logic [DEB_WIDTH-1:0] deb_cnt_i,
  input  logic                 deb_clr_i,
  output logic [NR_GPIOS-1:0]  in_o
);

  logic [NR_GPIOS-1:0]  sync1_q, sync2_q, last_q, in_q;
  logic [DEB_WIDTH-1:0] presc_q;
  logic                 deb_on, tick;

  assign deb_on = (deb_cnt_i != '0);
  // Tick when the prescaler reaches the programmed count; a clearing write
  // restarts the period without producing a tick.
  assign tick   = deb_on && !deb_clr_i && (presc_q >= deb_cnt_i);
  assign in_o   = in_q;

  // Two-flop synchroniser on every pad, independent of direction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler counts 0..deb_cnt and wraps; held at 0 when debounce is off.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      presc_q <= '0;
    end else if (deb_clr_i || !deb_on || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + DEB_WIDTH'(1);
    end
  end

  // Input register: direct load, or per-bit stability filter on ticks.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= '0;
      in_q   <= '0;
    end else if (!deb_on) begin
      in_q <= sync2_q;
    end else if (tick) begin
      last_q <= sync2_q;
      in_q   <= (sync2_q & ~(sync2_q ^ last_q)) | (in_q & (sync2_q ^ last_q));
    end
  end

endmodule

// File: rtl/as_gpio_ext.sv
// Wishbone-attached GPIO extension: direction/output registers with atomic
// set/clear/toggle, synchronised and debounced inputs, and edge-triggered
// sticky interrupt status with a mask.
//
// Bus handshake: a transfer is accepted on a rising edge where
// cyc & stb & !ack. Writes take effect and read data is captured on that
// edge; ack is high for exactly the following cycle, so back-to-back
// accesses complete at most once every two cycles. wbdDat_o is zero
// whenever ack is low.
module as_gpio_ext
  import as_pack::*;
#(
  parameter int NR_GPIOS   = 8,
  parameter int ADDR_WIDTH = 64,
  parameter int DEB_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] wbdAddr_i,
  input  logic [63:0]           wbdDat_i,
  output logic [63:0]           wbdDat_o,
  input  logic                  wbdWe_i,
  input  logic [7:0]            wbdSel_i,
  input  logic                  wbdStb_i,
  input  logic                  wbdCyc_i,
  output logic                  wbdAck_o,
  output logic                  gpio_irq_o,
  inout  wire  [NR_GPIOS-1:0]   gpio_io
);

  logic [NR_GPIOS-1:0]  dir_q, out_q, rise_en_q, fall_en_q, stat_q, mask_q;
  logic [NR_GPIOS-1:0]  in_q, in_prev_q, set_ev, w1c, stat_nxt, wd, wm;
  logic [DEB_WIDTH-1:0] deb_cnt_q;
  logic [63:0]          wmask, wdata_m, rdata;
  logic                 acc, wr, deb_clr;
  reg_sel_e             sel;
  logic                 unused_ok;

  assign unused_ok = ^{wbdAddr_i, wbdDat_i};

  assign acc     = wbdCyc_i && wbdStb_i && !wbdAck_o;
  assign wr      = acc && wbdWe_i;
  assign sel     = reg_decode(wbdAddr_i[6:3]);
  assign deb_clr = wr && (sel == REG_DEB_CNT);

  // Expand byte-lane enables into a bit mask.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < 8; b++) wmask[8*b +: 8] = {8{wbdSel_i[b]}};
  end

  assign wdata_m = wbdDat_i & wmask;
  assign wd      = wdata_m[NR_GPIOS-1:0];
  assign wm      = wmask[NR_GPIOS-1:0];

  // Read data multiplexer; bits above the pin count stay zero.
  always_comb begin
    rdata = '0;
    case (sel)
      REG_ID:       rdata = GPIO_EXT_ID_C;
      REG_DIR:      rdata[NR_GPIOS-1:0] = dir_q;
      REG_OUT:      rdata[NR_GPIOS-1:0] = out_q;
      REG_IN:       rdata[NR_GPIOS-1:0] = in_q;
      REG_RISE_EN:  rdata[NR_GPIOS-1:0] = rise_en_q;
      REG_FALL_EN:  rdata[NR_GPIOS-1:0] = fall_en_q;
      REG_IRQ_STAT: rdata[NR_GPIOS-1:0] = stat_q;
      REG_IRQ_MASK: rdata[NR_GPIOS-1:0] = mask_q;
      REG_DEB_CNT:  rdata[DEB_WIDTH-1:0] = deb_cnt_q;
      default:      rdata = '0;
    endcase
  end

  // Acknowledge and read-data register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wbdAck_o <= 1'b0;
      wbdDat_o <= '0;
    end else begin
      wbdAck_o <= acc;
      wbdDat_o <= (acc && !wbdWe_i) ? rdata : '0;
    end
  end

  // Software-writable registers with byte-lane gating.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dir_q     <= GPIO_EXT_DIR_RST_C[NR_GPIOS-1:0];
      out_q     <= GPIO_EXT_OUT_RST_C[NR_GPIOS-1:0];
      rise_en_q <= GPIO_EXT_RISE_EN_RST_C[NR_GPIOS-1:0];
      fall_en_q <= GPIO_EXT_FALL_EN_RST_C[NR_GPIOS-1:0];
      mask_q    <= GPIO_EXT_IRQ_MASK_RST_C[NR_GPIOS-1:0];
      deb_cnt_q <= GPIO_EXT_DEB_CNT_RST_C[DEB_WIDTH-1:0];
    end else if (wr) begin
      case (sel)
        REG_DIR:      dir_q     <= (dir_q & ~wm) | wd;
        REG_OUT:      out_q     <= (out_q & ~wm) | wd;
        REG_OUT_SET:  out_q     <= out_q | wd;
        REG_OUT_CLR:  out_q     <= out_q & ~wd;
        REG_OUT_TGL:  out_q     <= out_q ^ wd;
        REG_RISE_EN:  rise_en_q <= (rise_en_q & ~wm) | wd;
        REG_FALL_EN:  fall_en_q <= (fall_en_q & ~wm) | wd;
        REG_IRQ_MASK: mask_q    <= (mask_q & ~wm) | wd;
        REG_DEB_CNT:  deb_cnt_q <= (deb_cnt_q & ~wmask[DEB_WIDTH-1:0]) |
                                   wdata_m[DEB_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Edge events from the conditioned input; a new event wins over a W1C.
  assign set_ev   = (in_q & ~in_prev_q & rise_en_q) | (~in_q & in_prev_q & fall_en_q);
  assign w1c      = (wr && (sel == REG_IRQ_STAT)) ? wd : '0;
  assign stat_nxt = (stat_q & ~w1c) | set_ev;

  // Interrupt status and the previous-input register for edge detection.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_q    <= GPIO_EXT_IRQ_STAT_RST_C[NR_GPIOS-1:0];
      in_prev_q <= '0;
    end else begin
      stat_q    <= stat_nxt;
      in_prev_q <= in_q;
    end
  end

  assign gpio_irq_o = |(stat_q & mask_q);

  // Tri-state pad drivers.
  for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pad
    assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  as_gpio_sync_deb #(
    .NR_GPIOS  (NR_GPIOS),
    .DEB_WIDTH (DEB_WIDTH)
  ) u_sync_deb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pad_i     (gpio_io),
    .deb_cnt_i (deb_cnt_q),
    .deb_clr_i (deb_clr),
    .in_o      (in_q)
  );

endmodule

// File: tb/tb_as_gpio_ext.sv
// Bench for as_gpio_ext: directed bus transfers with hand-computed read
// data queued at issue time and checked by an independent ack monitor,
// plus direct checks on pads and the interrupt line.
module tb_as_gpio_ext;
  import as_pack::*;

  localparam int NR = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]   wbd_addr = '0;
  logic [63:0]   wbd_dat_w = '0;
  logic [63:0]   wbd_dat_r;
  logic          wbd_we = 1'b0;
  logic [7:0]    wbd_sel = '0;
  logic          wbd_stb = 1'b0;
  logic          wbd_cyc = 1'b0;
  logic          wbd_ack;
  logic          irq;
  wire  [NR-1:0] pads;
  logic [NR-1:0] pad_en = '1;
  logic [NR-1:0] pad_val = '0;

  for (genvar i = 0; i < NR; i++) begin : g_tb_pad
    assign pads[i] = pad_en[i] ? pad_val[i] : 1'bz;
  end

  as_gpio_ext #(.NR_GPIOS(NR), .ADDR_WIDTH(64), .DEB_WIDTH(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .wbdAddr_i  (wbd_addr),
    .wbdDat_i   (wbd_dat_w),
    .wbdDat_o   (wbd_dat_r),
    .wbdWe_i    (wbd_we),
    .wbdSel_i   (wbd_sel),
    .wbdStb_i   (wbd_stb),
    .wbdCyc_i   (wbd_cyc),
    .wbdAck_o   (wbd_ack),
    .gpio_irq_o (irq),
    .gpio_io    (pads)
  );

  // Scoreboard state
  int          checks = 0;
  int          failures = 0;
  int          acks_seen = 0;
  int          acks_exp = 0;
  logic [63:0] exp_q[$];
  bit          chk_q[$];
  string       name_q[$];
  logic        prev_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic bus(input bit we, input logic [7:0] offs, input logic [63:0] d,
                     input logic [7:0] sel, input logic [63:0] exp_rd, input string name);
    @(negedge clk);
    wbd_cyc = 1'b1; wbd_stb = 1'b1; wbd_we = we;
    wbd_addr = {56'h0, offs}; wbd_dat_w = d; wbd_sel = sel;
    exp_q.push_back(exp_rd); chk_q.push_back(!we); name_q.push_back(name);
    acks_exp++;
    @(posedge clk);
    @(negedge clk);
    wbd_cyc = 1'b0; wbd_stb = 1'b0; wbd_we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] offs, input logic [63:0] d);
    bus(1'b1, offs, d, 8'hFF, 64'h0, "write");
  endtask

  task automatic rd(input logic [7:0] offs, input logic [63:0] exp, input string name);
    bus(1'b0, offs, 64'h0, 8'hFF, exp, name);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops one expected entry per acknowledge.
  always @(negedge clk) begin
    if (rst_n && wbd_ack) begin
      acks_seen++;
      if (prev_ack) begin
        checks++; failures++;
        $display("FAIL ack_width: ack high on two consecutive cycles");
      end
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack: got ack with empty queue, required none");
      end else begin
        logic [63:0] e;
        bit          c;
        string       n;
        e = exp_q.pop_front(); c = chk_q.pop_front(); n = name_q.pop_front();
        if (c) check(n, wbd_dat_r, e);
      end
    end
    prev_ack = wbd_ack;
  end

  // Global time limit
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    wait_neg(3);
    check("rst_ack", {63'h0, wbd_ack}, 64'h0);
    check("rst_dat", wbd_dat_r, 64'h0);
    check("rst_irq", {63'h0, irq}, 64'h0);
    rst_n = 1'b1;

    rd(GPIO_EXT_ID_OFFS_C, GPIO_EXT_ID_C, "rd_id");
    rd(GPIO_EXT_DIR_OFFS_C, 64'h0, "rst_dir");
    rd(GPIO_EXT_OUT_OFFS_C, 64'h0, "rst_out");
    rd(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h0, "rst_stat");

    // Outputs
    pad_en = '0;
    wr(GPIO_EXT_DIR_OFFS_C, 64'hFF);
    wr(GPIO_EXT_OUT_OFFS_C, 64'hA5);
    wait_neg(1);
    check("pads_a5", {56'h0, pads}, 64'hA5);
    rd(GPIO_EXT_OUT_OFFS_C, 64'hA5, "rd_out_a5");
    bus(1'b1, GPIO_EXT_OUT_OFFS_C, 64'hFF, 8'h00, 64'h0, "write");
    rd(GPIO_EXT_OUT_OFFS_C, 64'hA5, "sel0_ignored");
    wr(GPIO_EXT_OUT_OFFS_C, 64'hFFFF_FFFF_FFFF_FF5A);
    rd(GPIO_EXT_OUT_OFFS_C, 64'h5A, "upper_bits_zero");

    wr(GPIO_EXT_OUT_OFFS_C, 64'hF0);
    wr(GPIO_EXT_OUT_SET_OFFS_C, 64'h0F);
    rd(GPIO_EXT_OUT_OFFS_C, 64'hFF, "out_set");
    wr(GPIO_EXT_OUT_CLR_OFFS_C, 64'h81);
    rd(GPIO_EXT_OUT_OFFS_C, 64'h7E, "out_clr");
    wr(GPIO_EXT_OUT_TGL_OFFS_C, 64'hFF);
    rd(GPIO_EXT_OUT_OFFS_C, 64'h81, "out_tgl");
    rd(GPIO_EXT_OUT_SET_OFFS_C, 64'h0, "rd_out_set_zero");
    check("pads_81", {56'h0, pads}, 64'h81);

    // Unmapped offsets
    rd(8'h60, 64'h0, "unmapped_rd");
    wr(8'h68, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(GPIO_EXT_OUT_OFFS_C, 64'h81, "unmapped_wr_ignored");

    // Direction change leaves OUT alone
    wr(GPIO_EXT_DIR_OFFS_C, 64'h00);
    pad_val = '0; pad_en = '1;
    rd(GPIO_EXT_OUT_OFFS_C, 64'h81, "dir_keeps_out");
    wait_neg(5);

    // Rise on pin 0 without debounce
    wr(GPIO_EXT_RISE_EN_OFFS_C, 64'h01);
    wr(GPIO_EXT_IRQ_MASK_OFFS_C, 64'h01);
    pad_val[0] = 1'b1;
    rd(GPIO_EXT_IN_OFFS_C, 64'h00, "in_not_yet");
    check("irq_n1", {63'h0, irq}, 64'h0);
    wait_neg(1);
    check("irq_n2", {63'h0, irq}, 64'h0);
    wait_neg(1);
    check("irq_n3", {63'h0, irq}, 64'h1);
    rd(GPIO_EXT_IN_OFFS_C, 64'h01, "in_pin0");
    rd(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h01, "stat_rise0");
    wr(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h01);
    check("irq_w1c", {63'h0, irq}, 64'h0);
    pad_val[0] = 1'b0;
    wait_neg(6);
    rd(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h00, "no_fall_stat");

    // Mask does not gate capture
    wr(GPIO_EXT_RISE_EN_OFFS_C, 64'h03);
    pad_val[1] = 1'b1;
    wait_neg(6);
    check("irq_masked", {63'h0, irq}, 64'h0);
    rd(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h02, "stat_masked");
    wr(GPIO_EXT_IRQ_MASK_OFFS_C, 64'h03);
    check("irq_unmasked", {63'h0, irq}, 64'h1);
    wr(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h02);
    check("irq_clr1", {63'h0, irq}, 64'h0);
    pad_val[1] = 1'b0;
    wait_neg(5);

    // Debounce with DEB_CNT=3, falling edge only
    wr(GPIO_EXT_RISE_EN_OFFS_C, 64'h00);
    wr(GPIO_EXT_FALL_EN_OFFS_C, 64'h02);
    wr(GPIO_EXT_IRQ_MASK_OFFS_C, 64'h02);
    wr(GPIO_EXT_DEB_CNT_OFFS_C, 64'h3);
    rd(GPIO_EXT_DEB_CNT_OFFS_C, 64'h3, "rd_deb");
    pad_val[1] = 1'b1;
    wait_neg(3);
    pad_val[1] = 1'b0;
    wait_neg(12);
    rd(GPIO_EXT_IN_OFFS_C, 64'h00, "glitch_filtered");
    pad_val[1] = 1'b1;
    wait_neg(10);
    rd(GPIO_EXT_IN_OFFS_C, 64'h02, "deb_in1");
    pad_val[1] = 1'b0;
    rd(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h00, "no_rise_stat");
    wait_neg(16);
    check("irq_fall", {63'h0, irq}, 64'h1);
    rd(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h02, "stat_fall1");
    wr(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h02);
    wr(GPIO_EXT_DEB_CNT_OFFS_C, 64'h0);
    wr(GPIO_EXT_FALL_EN_OFFS_C, 64'h00);

    // W1C colliding with a new rise
    wr(GPIO_EXT_RISE_EN_OFFS_C, 64'h01);
    wr(GPIO_EXT_IRQ_MASK_OFFS_C, 64'h01);
    pad_val[0] = 1'b1;
    wait_neg(6);
    check("irq_pre_collide", {63'h0, irq}, 64'h1);
    pad_val[0] = 1'b0;
    wait_neg(5);
    pad_val[0] = 1'b1;
    repeat (3) @(posedge clk);
    wr(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h01);
    check("irq_collide", {63'h0, irq}, 64'h1);
    rd(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h01, "stat_collide");
    wr(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h01);
    check("irq_after_clr", {63'h0, irq}, 64'h0);
    pad_val[0] = 1'b0;
    wait_neg(5);
    pad_val[0] = 1'b1;
    wait_neg(6);
    wr(GPIO_EXT_DEB_CNT_OFFS_C, 64'h5);
    check("irq_before_rst", {63'h0, irq}, 64'h1);

    // Reset during a read
    @(negedge clk);
    wbd_cyc = 1'b1; wbd_stb = 1'b1; wbd_we = 1'b0;
    wbd_addr = {56'h0, GPIO_EXT_OUT_OFFS_C};
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    wbd_cyc = 1'b0; wbd_stb = 1'b0;
    #1;
    check("abort_ack", {63'h0, wbd_ack}, 64'h0);
    check("abort_dat", wbd_dat_r, 64'h0);
    check("abort_irq", {63'h0, irq}, 64'h0);
    wait_neg(3);
    check("abort_no_ack", {63'h0, wbd_ack}, 64'h0);
    rst_n = 1'b1;
    rd(GPIO_EXT_OUT_OFFS_C, 64'h0, "post_rst_out");
    rd(GPIO_EXT_DIR_OFFS_C, 64'h0, "post_rst_dir");
    rd(GPIO_EXT_RISE_EN_OFFS_C, 64'h0, "post_rst_rise");
    rd(GPIO_EXT_IRQ_MASK_OFFS_C, 64'h0, "post_rst_mask");
    rd(GPIO_EXT_DEB_CNT_OFFS_C, 64'h0, "post_rst_deb");
    wait_neg(6);
    rd(GPIO_EXT_IRQ_STAT_OFFS_C, 64'h0, "post_rst_stat");
    rd(GPIO_EXT_IN_OFFS_C, 64'h01, "post_rst_in");
    check("post_rst_irq", {63'h0, irq}, 64'h0);

    // Final report
    wait_neg(3);
    check("ack_count", 64'(acks_seen), 64'(acks_exp));
    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/as_gpio_ext.md
AS_GPIO_EXT -- requirements
Module: as_gpio_ext

Interface
REQ-001 NR_GPIOS, 8, number of GPIO pins SHALL be 1..64.
REQ-002 ADDR_WIDTH, 64, Wishbone address width.
REQ-003 DEB_WIDTH, 16, debounce prescaler width.
REQ-004 clk_i  input  1  sole clock; all flops SHALL use the rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 wbdAddr_i  input  ADDR_WIDTH  byte address; bits [6:3] SHALL select the register.
REQ-007 wbdDat_i  input  64  write data.
REQ-008 wbdDat_o  output  64  read data, valid while wbdAck_o is high.
REQ-009 wbdWe_i  input  1  write (1) or read (0).
REQ-010 wbdSel_i  input  8  byte-lane enables.
REQ-011 wbdStb_i  input  1  valid cycle.
REQ-012 wbdCyc_i  input  1  bus cycle active.
REQ-013 wbdAck_o  output  1  transfer acknowledge.
REQ-014 gpio_irq_o  output  1  level interrupt request.
REQ-015 gpio_io  inout  NR_GPIOS  tri-state pads.

Function
REQ-016 An access SHALL be accepted on an edge where cyc&stb&!ack; wbdAck_o SHALL be high exactly one cycle after acceptance, then low; max rate one access per 2 cycles.
REQ-017 Writes SHALL take effect on the acceptance edge, per byte lane gated by wbdSel_i; read data SHALL be registered on the same edge; bits >= NR_GPIOS SHALL read 0 and ignore writes.
REQ-018 The register map SHALL be: 0x00 ID RO=GPIO_EXT_ID_C; 0x08 DIR RW (1=output); 0x10 OUT RW; 0x18 OUT_SET W; 0x20 OUT_CLR W; 0x28 OUT_TGL W; 0x30 IN RO; 0x38 RISE_EN RW; 0x40 FALL_EN RW; 0x48 IRQ_STAT RW1C; 0x50 IRQ_MASK RW; 0x58 DEB_CNT RW (DEB_WIDTH bits).
REQ-019 Unmapped offsets SHALL read 0, ignore writes, and still ack.
REQ-020 OUT_SET, OUT_CLR and OUT_TGL SHALL read 0 and apply OUT|=d, OUT&=~d and OUT^=d respectively in a single cycle.
REQ-021 gpio_io[i] SHALL be driven with OUT[i] when DIR[i]=1, else high-Z; pad inputs SHALL be sampled regardless of DIR.
REQ-022 Every pad input SHALL pass a 2-flop synchroniser (sync1, sync2) before use.
REQ-023 With DEB_CNT=0, IN SHALL load sync2 every cycle; a pad change captured by sync1 at edge N SHALL appear in IN at edge N+2.
REQ-024 With DEB_CNT=k>0, a prescaler SHALL count 0..k, tick at k and wrap to 0; on a tick, last<=sync2, and IN[i]<=sync2[i] only if sync2[i]==last[i] (stable across two ticks).
REQ-025 Any write to DEB_CNT SHALL clear the prescaler to 0.
REQ-026 Edge detection SHALL use IN versus IN_prev (IN_prev updated every cycle); rise=IN&~IN_prev, fall=~IN&IN_prev.
REQ-027 IRQ_STAT[i] SHALL set on the edge after a rise (if RISE_EN[i]) or fall (if FALL_EN[i]), and stay set until software writes 1 to that bit.
REQ-028 When a set event and a W1C hit the same bit on the same edge, the bit SHALL remain set.
REQ-029 gpio_irq_o SHALL equal |(IRQ_STAT & IRQ_MASK), combinational from registers; the mask SHALL NOT gate status capture.
REQ-030 Writing DIR SHALL NOT alter OUT, IN or IRQ state.

Reset
REQ-031 With rst_i low, DIR, OUT, RISE_EN, FALL_EN, IRQ_STAT, IRQ_MASK, DEB_CNT, prescaler, last, sync1, sync2, IN, IN_prev, wbdAck_o, wbdDat_o and gpio_irq_o SHALL be 0 and all pads high-Z.
REQ-032 Assertion of rst_i mid-transfer SHALL abort the transfer with no ack issued.
REQ-033 The first access SHALL be accepted on the first rising edge with rst_i high; pads high at release SHALL raise no IRQ, since RISE_EN=0.

Structure
REQ-034 as_pack SHALL hold the GPIO_EXT_*_OFFS_C offsets, GPIO_EXT_ID_C and the register reset constants.
REQ-035 One sub-module as_gpio_sync_deb (synchroniser, prescaler, debounce; params NR_GPIOS, DEB_WIDTH) SHALL be instantiated; bus decode and IRQ logic stay in the top.

Verification
REQ-036 Write DIR=0xFF, OUT=0xA5 -> pads 0xA5 on the edge after the write ack; read OUT=0xA5.
REQ-037 OUT=0xF0; OUT_SET 0x0F, then OUT_CLR 0x81, then OUT_TGL 0xFF -> OUT 0xFF, 0x7E, 0x81; reading OUT_SET returns 0.
REQ-038 DEB_CNT=0, RISE_EN=0x01, MASK=0x01, pad0 0->1 -> IN[0]=1 after 2 cycles, gpio_irq_o high next cycle; W1C 0x01 -> irq low.
REQ-039 DEB_CNT=3, 3-cycle glitch on pad1 -> IN unchanged; 12-cycle high -> IN[1]=1 within 8 cycles; FALL_EN only -> no IRQ_STAT on the rise.
REQ-040 W1C of bit0 on the same edge as a new rise on pin0 -> IRQ_STAT[0] stays 1; rst_i low mid-read -> no ack, all registers 0.
